// File: rtl/dfg_decoder.sv
// dfg_decoder: inverts the double Feynman encode (p=a, q=a^b, r=a^c) per lane.
// One input stage register (S1) feeds a DEPTH-entry output FIFO; in_ready counts
// S1 as occupied, so a captured triple always has a FIFO slot waiting for it.
// Optional macro DFG_DEC_STATS_EN adds a 16-bit output handshake counter
// (frame_cnt) and a sticky wrap flag (cnt_wrap).
module dfg_decoder #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_p,
  input  logic [W-1:0]           in_q,
  input  logic [W-1:0]           in_r,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_a,
  output logic [W-1:0]           out_b,
  output logic [W-1:0]           out_c,
  output logic [$clog2(DEPTH):0] level
`ifdef DFG_DEC_STATS_EN
  ,
  output logic [15:0]            frame_cnt,
  output logic                   cnt_wrap
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned OW = LW + 1;
  localparam int unsigned TW = 3 * W;

  logic          r_s1_valid;
  logic [W-1:0]  r_s1_p;
  logic [W-1:0]  r_s1_q;
  logic [W-1:0]  r_s1_r;
  logic [TW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_wr;
  logic [OW-1:0] w_occ;
  logic [TW-1:0] w_dec;
  logic [TW-1:0] w_head;

  // Handshakes and occupancy; in_ready looks at registers only (plus reset gating)
  assign w_occ     = OW'(r_level) + OW'(r_s1_valid);
  assign in_ready  = ~rst & (w_occ < OW'(DEPTH));
  assign out_valid = (r_level != '0);
  assign w_in_hs   = in_valid & in_ready;
  assign w_out_hs  = out_valid & out_ready;
  assign w_wr      = r_s1_valid;
  assign level     = r_level;

  // Decode the staged triple: a=p, b=q^p, c=r^p
  assign w_dec  = {r_s1_p, r_s1_q ^ r_s1_p, r_s1_r ^ r_s1_p};
  assign w_head = r_mem[r_rptr];

  // Head entry presented on the outputs, forced to zero while empty
  assign out_a = out_valid ? w_head[TW-1 -: W]  : '0;
  assign out_b = out_valid ? w_head[2*W-1 -: W] : '0;
  assign out_c = out_valid ? w_head[W-1:0]      : '0;

  // Input stage register: holds a captured triple for exactly one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_q     <= '0;
      r_s1_r     <= '0;
    end else begin
      r_s1_valid <= w_in_hs;
      if (w_in_hs) begin
        r_s1_p <= in_p;
        r_s1_q <= in_q;
        r_s1_r <= in_r;
      end
    end
  end

  // Output FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= w_dec;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_out_hs) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_out_hs})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef DFG_DEC_STATS_EN
  logic [15:0] r_frame_cnt;
  logic        r_cnt_wrap;

  assign frame_cnt = r_frame_cnt;
  assign cnt_wrap  = r_cnt_wrap;

  // Output handshake counter with sticky wrap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_cnt_wrap  <= 1'b0;
    end else if (w_out_hs) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_frame_cnt == 16'hFFFF) begin
        r_cnt_wrap <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dfg_decoder.sv
// tb_dfg_decoder: directed and randomized checks of dfg_decoder against a
// queue-based reference of original (a,b,c) triples encoded by the bench.
module tb_dfg_decoder;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_p, in_q, in_r;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_a, out_b, out_c;
  logic [LW-1:0] level;
`ifdef DFG_DEC_STATS_EN
  logic [15:0]   frame_cnt;
  logic          cnt_wrap;
`endif

  dfg_decoder #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_q      (in_q),
    .in_r      (in_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .level     (level)
`ifdef DFG_DEC_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .cnt_wrap  (cnt_wrap)
`endif
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  int nout  = 0;
  int idx, n0, sent, budget;
  logic hs;
  logic [W-1:0] va [6];
  logic [W-1:0] vb [6];
  logic [W-1:0] vc [6];
  logic [W-1:0] cur_a, cur_b, cur_c;
  logic [3*W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encode an original triple onto the input lanes and remember the original
  task automatic present(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    cur_a = a; cur_b = b; cur_c = c;
    in_p  = a;
    in_q  = a ^ b;
    in_r  = a ^ c;
  endtask

  // One clock with scoreboard bookkeeping: outputs must always show the oldest
  // accepted, not-yet-consumed original triple (or zeros when nothing is visible)
  task automatic cyc();
    logic hs_in, hs_out;
    logic [3*W-1:0] obs;
    obs = {out_a, out_b, out_c};
    if (out_valid) begin
      if (exp_q.size() == 0) check("out_valid_with_nothing_pending", 32'(out_valid), 32'd0);
      else                   check("out_data", 32'(obs), 32'(exp_q[0]));
    end else begin
      check("out_zero_when_empty", 32'(obs), 32'd0);
    end
    hs_in  = in_valid && in_ready;
    hs_out = out_valid && out_ready;
    tick();
    if (hs_out && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      nout++;
    end
    if (hs_in) exp_q.push_back({cur_a, cur_b, cur_c});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_p = '0; in_q = '0; in_r = '0;
    cur_a = '0; cur_b = '0; cur_c = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_data", 32'({out_a, out_b, out_c}), 32'd0);
`ifdef DFG_DEC_STATS_EN
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_cnt_wrap", 32'(cnt_wrap), 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_level", 32'(level), 32'd0);

    // Single triple: p=A5 q=0F r=FF decodes to A5/AA/5A
    out_ready = 1'b1;
    in_p = 8'hA5; in_q = 8'h0F; in_r = 8'hFF;
    in_valid = 1'b1;
    check("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t1_out_valid_k", 32'(out_valid), 32'd0);
    check("t1_level_k", 32'(level), 32'd0);
    tick();
    check("t1_out_valid_k1", 32'(out_valid), 32'd1);
    check("t1_out_a", 32'(out_a), 32'hA5);
    check("t1_out_b", 32'(out_b), 32'hAA);
    check("t1_out_c", 32'(out_c), 32'h5A);
    check("t1_level_k1", 32'(level), 32'd1);
    tick();
    check("t1_out_valid_k2", 32'(out_valid), 32'd0);
    check("t1_level_k2", 32'(level), 32'd0);
    check("t1_out_zero", 32'({out_a, out_b, out_c}), 32'd0);

    // Backpressure: six offered, four fit (FIFO + stage), then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom); vc[i] = W'($urandom);
    end
    idx = 0;
    n0  = nout;
    for (int i = 0; i < 6; i++) begin
      present(va[idx], vb[idx], vc[idx]);
      in_valid = 1'b1;
      hs = in_ready;
      cyc();
      if (hs) idx++;
    end
    check("t2_accepted", 32'(idx), 32'd4);
    check("t2_level_full", 32'(level), 32'(DEPTH));
    check("t2_in_ready_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (idx == 6 && exp_q.size() == 0) break;
      if (idx < 6) begin
        present(va[idx], vb[idx], vc[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      hs = in_valid && in_ready;
      cyc();
      if (hs) idx++;
    end
    in_valid = 1'b0;
    check("t2_outputs", 32'(nout - n0), 32'd6);
    check("t2_pending", 32'(exp_q.size()), 32'd0);

    // Streaming: one triple per cycle, level settles at 1
    out_ready = 1'b1;
    n0 = nout;
    for (int i = 0; i < 20; i++) begin
      present(W'(i), W'($urandom), W'($urandom));
      in_valid = 1'b1;
      check("t3_in_ready", 32'(in_ready), 32'd1);
      if (i >= 2) begin
        check("t3_level", 32'(level), 32'd1);
        check("t3_out_valid", 32'(out_valid), 32'd1);
      end
      cyc();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    check("t3_outputs", 32'(nout - n0), 32'd20);

    // Reset mid-operation with three in the FIFO and one in the stage
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(W'($urandom), W'($urandom), W'($urandom));
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    check("t4_level_pre", 32'(level), 32'd3);
    rst = 1'b1;
    #1;
    check("t4_rst_out_valid", 32'(out_valid), 32'd0);
    check("t4_rst_level", 32'(level), 32'd0);
    check("t4_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t4_post_in_ready", 32'(in_ready), 32'd1);
    for (int t = 0; t < 5; t++) begin
      check("t4_no_stale", 32'(out_valid), 32'd0);
      cyc();
    end

    // Random round trip: 1000 triples, random valid and random backpressure
    n0 = nout;
    sent = 0;
    budget = 0;
    while ((nout - n0) < 1000 && budget < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 1000) begin
        in_valid = ($urandom_range(0, 3) != 0);
        present(W'($urandom), W'($urandom), W'($urandom));
      end else begin
        in_valid = 1'b0;
      end
      hs = in_valid && in_ready;
      check("t5_level_bound", 32'(level <= LW'(DEPTH)), 32'd1);
      cyc();
      if (hs) sent++;
      budget++;
    end
    in_valid = 1'b0;
    check("t5_outputs", 32'(nout - n0), 32'd1000);
    check("t5_pending", 32'(exp_q.size()), 32'd0);

`ifdef DFG_DEC_STATS_EN
    // Counter wrap: 65537 output handshakes leave frame_cnt=1, cnt_wrap=1
    rst = 1'b1;
    #1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("t6_frame_cnt_rst", 32'(frame_cnt), 32'd0);
    check("t6_cnt_wrap_rst", 32'(cnt_wrap), 32'd0);
    out_ready = 1'b1;
    sent = 0;
    n0 = 0;
    budget = 0;
    while (n0 < 65537 && budget < 70000) begin
      in_valid = (sent < 65537);
      present(W'(sent), 8'h00, 8'h00);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) n0++;
      tick();
      budget++;
    end
    in_valid = 1'b0;
    check("t6_handshakes", 32'(n0), 32'd65537);
    check("t6_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t6_cnt_wrap", 32'(cnt_wrap), 32'd1);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/dfg_decoder.md
DFG_DECODER -- requirements
Module: dfg_decoder

Interface
REQ-001 Parameter W, default 8, lane width in bits (W >= 1).
REQ-002 Parameter DEPTH, default 4, output FIFO entries (power of 2, >= 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  encoded triple present on in_p/in_q/in_r.
REQ-006 in_ready  output  1  decoder can accept a triple this cycle.
REQ-007 in_p, in_q, in_r  input  W each  encoded lanes, bitwise p=a, q=a^b, r=a^c.
REQ-008 out_valid  output  1  decoded triple present on out_a/out_b/out_c.
REQ-009 out_ready  input  1  consumer accepts a decoded triple.
REQ-010 out_a, out_b, out_c  output  W each  recovered lanes.
REQ-011 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 frame_cnt  output  16  decoded-triple counter (present only with DFG_DEC_STATS_EN).
REQ-013 cnt_wrap  output  1  sticky counter-wrap flag (present only with DFG_DEC_STATS_EN).

Function
REQ-014 Decode, bitwise per lane: a=p, b=q^p, c=r^p; exact inverse of the double Feynman encode.
REQ-015 Input handshake on an edge where in_valid && in_ready; triple latched into stage register S1 (s1_valid set).
REQ-016 S1 not refilled in a cycle: s1_valid cleared on the following edge unless a new handshake occurs that edge.
REQ-017 S1 contents decoded and written to FIFO tail on the edge after capture; one write per edge maximum.
REQ-018 in_ready = (level + s1_valid) < DEPTH, from registers only; a same-cycle output pop does not raise in_ready.
REQ-019 Latency: triple accepted at edge k -> out_valid high after edge k+1 if FIFO was empty.
REQ-020 out_valid = (level != 0); out_a/b/c = head entry; all three driven 0 when empty.
REQ-021 Output handshake on an edge where out_valid && out_ready; head popped, level decremented.
REQ-022 Simultaneous FIFO write and pop: level unchanged, both pointers advance.
REQ-023 Full: level == DEPTH -> in_ready low; in_valid ignored; no data lost or overwritten.
REQ-024 Pointers wrap modulo DEPTH; order strictly FIFO, no reordering or duplication.
REQ-025 out_valid, once high, stays high and out data stable until handshake.
REQ-026 Sustained throughput one triple per cycle when out_ready held high.

Reset
REQ-027 rst asserted: S1 and FIFO cleared, pointers 0, level 0, out_valid 0, in_ready 0 while rst high, outputs 0.
REQ-028 In-flight triples (S1 or FIFO) discarded on rst; none emitted after release.
REQ-029 First edge after rst release: in_ready 1 (level 0, s1_valid 0).
REQ-030 With DFG_DEC_STATS_EN: frame_cnt 0 and cnt_wrap 0 on reset.

Configuration
REQ-031 Macro DFG_DEC_STATS_EN defined: frame_cnt increments by 1 on each output handshake, wraps 0xFFFF->0x0000; cnt_wrap set on that wrap, cleared only by rst.
REQ-032 DFG_DEC_STATS_EN undefined: frame_cnt and cnt_wrap ports and logic absent; all other behaviour identical.

Verification
REQ-033 Single triple p=0xA5,q=0x0F,r=0xFF, out_ready=1 -> out_valid after edge k+1, a=0xA5,b=0xAA,c=0x5A, level 1 then 0.
REQ-034 out_ready=0, stream 6 triples -> exactly 4 accepted, in_ready low with level=4, s1_valid=0; release out_ready -> 4 outputs in order, then remaining 2.
REQ-035 out_ready=1, in_valid=1 for 20 cycles with incrementing p -> 20 outputs, one per cycle, level steady at 1.
REQ-036 rst pulse mid-operation with level=3 and S1 full -> out_valid 0 immediately, no stale output after release, in_ready 1 next edge.
REQ-037 Round-trip: random a,b,c (1000 triples) encoded by reference model, random out_ready -> outputs equal originals.
REQ-038 With DFG_DEC_STATS_EN: 65537 handshakes -> frame_cnt=1, cnt_wrap=1.
